// File: rtl/ddr_arb_pkg.sv
// Shared widths and FSM state type for the DDR Avalon-MM arbiter.
package ddr_arb_pkg;
  localparam int AMM_ADDR_W  = 25;
  localparam int AMM_DATA_W  = 256;
  localparam int AMM_BE_W    = 32;
  localparam int AMM_BURST_W = 7;

  typedef enum logic [1:0] {IDLE, WRITE, RD_CMD, RD_WAIT} arb_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick: first active request at or after i_ptr, wrapping.
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IDX_W   = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [IDX_W-1:0]   i_ptr,
  output logic [NUM_REQ-1:0] o_gnt,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_any
);

  function automatic logic [IDX_W-1:0] wrap_idx(input int v);
    return IDX_W'(v % NUM_REQ);
  endfunction

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!o_any && i_req[wrap_idx(int'(i_ptr) + i)]) begin
        o_any                             = 1'b1;
        o_idx                             = wrap_idx(int'(i_ptr) + i);
        o_gnt[wrap_idx(int'(i_ptr) + i)]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ddr_amm_arbiter.sv
// Round-robin, burst-locked sharing of one Avalon-MM DDR port among NUM_REQ requesters.
// Optional read watchdog and timeout_err port enabled by defining ARB_RD_TIMEOUT_EN.
module ddr_amm_arbiter
  import ddr_arb_pkg::*;
#(
  parameter int NUM_REQ     = 2,
  parameter int MAX_BURST   = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic                             avalon_clk,
  input  logic                             avalon_reset,
  input  logic                             cal_success,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_write,
  input  logic [NUM_REQ*AMM_ADDR_W-1:0]    req_addr,
  input  logic [NUM_REQ*AMM_BURST_W-1:0]   req_burst,
  input  logic [NUM_REQ*AMM_DATA_W-1:0]    req_wdata,
  input  logic [NUM_REQ*AMM_BE_W-1:0]      req_be,
  output logic [NUM_REQ-1:0]               req_accept,
  output logic [NUM_REQ-1:0]               wbeat_ack,
  output logic [NUM_REQ-1:0]               rd_valid,
  output logic [AMM_DATA_W-1:0]            rd_data,
  output logic [NUM_REQ-1:0]               req_done,
  output logic [NUM_REQ-1:0]               grant,
  output logic                             busy,
`ifdef ARB_RD_TIMEOUT_EN
  output logic                             timeout_err,
`endif
  output logic [AMM_ADDR_W-1:0]            amm_addr,
  output logic [AMM_DATA_W-1:0]            amm_writedata,
  output logic [AMM_BE_W-1:0]              amm_byteenable,
  output logic [AMM_BURST_W-1:0]           amm_burstcount,
  output logic                             amm_read,
  output logic                             amm_write,
  input  logic [AMM_DATA_W-1:0]            amm_readdata,
  input  logic                             amm_readdatavalid,
  input  logic                             amm_ready
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 127 || TIMEOUT_CYC < 1) begin : g_bad_cfg
    $error("ddr_amm_arbiter: illegal parameter set");
  end

  function automatic logic [AMM_BURST_W-1:0] sat_burst(input logic [AMM_BURST_W-1:0] b);
    if (b == '0) return AMM_BURST_W'(1);
    if (int'(b) > MAX_BURST) return AMM_BURST_W'(MAX_BURST);
    return b;
  endfunction

  arb_state_t              r_state;
  logic [IDX_W-1:0]        r_ptr;
  logic [AMM_BURST_W-1:0]  r_beat;
  logic [NUM_REQ-1:0]      r_accept;
  logic [NUM_REQ-1:0]      r_grant;
  logic                    r_busy;
  logic [AMM_ADDR_W-1:0]   r_addr;
  logic [AMM_BURST_W-1:0]  r_burst;
  logic                    r_read;
  logic                    r_write;
  logic [NUM_REQ-1:0]      r_rd_valid;
  logic [AMM_DATA_W-1:0]   r_rd_data;
  logic [NUM_REQ-1:0]      r_rd_done;

  logic [NUM_REQ-1:0]      w_gnt;
  logic [IDX_W-1:0]        w_idx;
  logic                    w_any;
  logic [AMM_ADDR_W-1:0]   w_win_addr;
  logic [AMM_BURST_W-1:0]  w_win_burst;
  logic                    w_wbeat;
  logic                    w_wlast;
  logic                    w_rlast;
  logic [AMM_DATA_W-1:0]   w_wdata;
  logic [AMM_BE_W-1:0]     w_be;

`ifdef ARB_RD_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYC + 1);
  logic [TMO_W-1:0]        r_tmo;
  logic                    r_timeout;
  assign timeout_err = r_timeout;
`endif

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr (
    .i_req   (req_valid),
    .i_ptr   (r_ptr),
    .o_gnt   (w_gnt),
    .o_idx   (w_idx),
    .o_any   (w_any)
  );

  assign w_win_addr  = req_addr[int'(w_idx)*AMM_ADDR_W +: AMM_ADDR_W];
  assign w_win_burst = req_burst[int'(w_idx)*AMM_BURST_W +: AMM_BURST_W];

  // Write beats are acknowledged combinationally so the owner can advance its data next cycle.
  assign w_wbeat = r_write & amm_ready;
  assign w_wlast = w_wbeat && (r_beat == r_burst - AMM_BURST_W'(1));
  assign w_rlast = amm_readdatavalid && (r_beat == r_burst - AMM_BURST_W'(1));

  always_comb begin
    w_wdata = '0;
    w_be    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (r_grant[i]) begin
        w_wdata = w_wdata | req_wdata[i*AMM_DATA_W +: AMM_DATA_W];
        w_be    = w_be    | req_be[i*AMM_BE_W +: AMM_BE_W];
      end
    end
  end

  assign req_accept     = r_accept;
  assign grant          = r_grant;
  assign busy           = r_busy;
  assign amm_addr       = r_addr;
  assign amm_burstcount = r_burst;
  assign amm_read       = r_read;
  assign amm_write      = r_write;
  assign amm_writedata  = w_wdata;
  assign amm_byteenable = w_be;
  assign rd_valid       = r_rd_valid;
  assign rd_data        = r_rd_data;
  assign wbeat_ack      = r_grant & {NUM_REQ{w_wbeat}};
  assign req_done       = (r_grant & {NUM_REQ{w_wlast}}) | r_rd_done;

  always_ff @(posedge avalon_clk or posedge avalon_reset) begin
    if (avalon_reset) begin
      r_state    <= IDLE;
      r_ptr      <= '0;
      r_beat     <= '0;
      r_accept   <= '0;
      r_grant    <= '0;
      r_busy     <= 1'b0;
      r_addr     <= '0;
      r_burst    <= '0;
      r_read     <= 1'b0;
      r_write    <= 1'b0;
      r_rd_valid <= '0;
      r_rd_data  <= '0;
      r_rd_done  <= '0;
`ifdef ARB_RD_TIMEOUT_EN
      r_tmo      <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_accept   <= '0;
      r_rd_valid <= '0;
      r_rd_done  <= '0;
      case (r_state)
        IDLE: begin
          if (cal_success && w_any) begin
            r_accept <= w_gnt;
            r_grant  <= w_gnt;
            r_busy   <= 1'b1;
            r_addr   <= w_win_addr;
            r_burst  <= sat_burst(w_win_burst);
            r_beat   <= '0;
            r_ptr    <= (int'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
`ifdef ARB_RD_TIMEOUT_EN
            r_tmo    <= '0;
`endif
            if (req_write[w_idx]) begin
              r_write <= 1'b1;
              r_state <= WRITE;
            end else begin
              r_read  <= 1'b1;
              r_state <= RD_CMD;
            end
          end
        end
        WRITE: begin
          if (w_wbeat) begin
            if (w_wlast) begin
              r_write <= 1'b0;
              r_grant <= '0;
              r_busy  <= 1'b0;
              r_beat  <= '0;
              r_state <= IDLE;
            end else begin
              r_beat  <= r_beat + AMM_BURST_W'(1);
            end
          end
        end
        RD_CMD: begin
          if (amm_ready) begin
            r_read  <= 1'b0;
            r_state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (amm_readdatavalid) begin
            r_rd_data  <= amm_readdata;
            r_rd_valid <= r_grant;
`ifdef ARB_RD_TIMEOUT_EN
            r_tmo      <= '0;
`endif
            if (w_rlast) begin
              r_rd_done <= r_grant;
              r_grant   <= '0;
              r_busy    <= 1'b0;
              r_beat    <= '0;
              r_state   <= IDLE;
            end else begin
              r_beat    <= r_beat + AMM_BURST_W'(1);
            end
          end
`ifdef ARB_RD_TIMEOUT_EN
          // Watchdog: abandon a read whose data never arrives.
          else if (r_tmo == TMO_W'(TIMEOUT_CYC - 1)) begin
            r_rd_done <= r_grant;
            r_timeout <= 1'b1;
            r_grant   <= '0;
            r_busy    <= 1'b0;
            r_beat    <= '0;
            r_tmo     <= '0;
            r_state   <= IDLE;
          end else begin
            r_tmo     <= r_tmo + TMO_W'(1);
          end
`endif
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr_amm_arbiter.sv
// Directed self-checking bench for ddr_amm_arbiter (two requesters, timeout tests when ARB_RD_TIMEOUT_EN is set).
module tb_ddr_amm_arbiter;
  localparam int NR = 2;

  logic                 avalon_clk = 1'b0;
  logic                 avalon_reset = 1'b1;
  logic                 cal_success = 1'b0;
  logic [NR-1:0]        req_valid = '0;
  logic [NR-1:0]        req_write = '0;
  logic [NR*25-1:0]     req_addr = '0;
  logic [NR*7-1:0]      req_burst = '0;
  logic [NR*256-1:0]    req_wdata = '0;
  logic [NR*32-1:0]     req_be = '0;
  logic [NR-1:0]        req_accept;
  logic [NR-1:0]        wbeat_ack;
  logic [NR-1:0]        rd_valid;
  logic [255:0]         rd_data;
  logic [NR-1:0]        req_done;
  logic [NR-1:0]        grant;
  logic                 busy;
  logic [24:0]          amm_addr;
  logic [255:0]         amm_writedata;
  logic [31:0]          amm_byteenable;
  logic [6:0]           amm_burstcount;
  logic                 amm_read;
  logic                 amm_write;
  logic [255:0]         amm_readdata = '0;
  logic                 amm_readdatavalid = 1'b0;
  logic                 amm_ready = 1'b0;
`ifdef ARB_RD_TIMEOUT_EN
  logic                 timeout_err;
`endif

  int n_chk = 0;
  int n_err = 0;

  ddr_amm_arbiter #(.NUM_REQ(NR), .MAX_BURST(64), .TIMEOUT_CYC(16)) dut (
    .avalon_clk        (avalon_clk),
    .avalon_reset      (avalon_reset),
    .cal_success       (cal_success),
    .req_valid         (req_valid),
    .req_write         (req_write),
    .req_addr          (req_addr),
    .req_burst         (req_burst),
    .req_wdata         (req_wdata),
    .req_be            (req_be),
    .req_accept        (req_accept),
    .wbeat_ack         (wbeat_ack),
    .rd_valid          (rd_valid),
    .rd_data           (rd_data),
    .req_done          (req_done),
    .grant             (grant),
    .busy              (busy),
`ifdef ARB_RD_TIMEOUT_EN
    .timeout_err       (timeout_err),
`endif
    .amm_addr          (amm_addr),
    .amm_writedata     (amm_writedata),
    .amm_byteenable    (amm_byteenable),
    .amm_burstcount    (amm_burstcount),
    .amm_read          (amm_read),
    .amm_write         (amm_write),
    .amm_readdata      (amm_readdata),
    .amm_readdatavalid (amm_readdatavalid),
    .amm_ready         (amm_ready)
  );

  always #5 avalon_clk = ~avalon_clk;

  task automatic chk(input string tag, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge avalon_clk);
    #1;
  endtask

  task automatic do_reset();
    avalon_reset = 1'b1;
    req_valid = '0;
    amm_readdatavalid = 1'b0;
    cyc();
    cyc();
    avalon_reset = 1'b0;
    cyc();
  endtask

  // Acts as the EMIF: returns nsend beats starting the cycle after amm_read is accepted.
  task automatic run_read(input int nsend, output int nrv, output int ndone);
    int pend;
    pend = 0;
    nrv = 0;
    ndone = 0;
    for (int c = 0; c < nsend + 12; c++) begin
      nrv += $countones(rd_valid);
      if (req_done != '0) ndone++;
      if (pend > 0) begin
        amm_readdatavalid = 1'b1;
        amm_readdata = {8{32'hC0DE0000 | 32'(c)}};
        pend--;
      end else begin
        amm_readdatavalid = 1'b0;
      end
      if (amm_read && amm_ready) pend = nsend;
      cyc();
    end
    amm_readdatavalid = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int acks, dones, beat, nacc, ndone, nrv, pend, seq, guard;
    int rdv_cnt[NR];
    logic [NR-1:0] acc_seq[4];
    int acc_cyc[4];
    int done_cyc[4];
    logic [255:0] prev_data;
    bit pat[6];
    pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

    // Reset state
    cyc();
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_amm_write", amm_write, 0);
    chk("rst_amm_read", amm_read, 0);
    chk("rst_accept", req_accept, 0);
    chk("rst_addr", amm_addr, 0);
    chk("rst_done", req_done, 0);
    avalon_reset = 1'b0;
    cyc();

    // No grant while uncalibrated
    req_valid = 2'b01;
    req_write = 2'b01;
    req_addr[24:0] = 25'h10;
    req_burst[6:0] = 7'd4;
    req_wdata[255:0] = 256'hA0;
    req_be[31:0] = 32'hF0F0_0000;
    nacc = 0;
    for (int c = 0; c < 100; c++) begin
      cyc();
      if (req_accept != '0 || busy) nacc++;
    end
    chk("nocal_accepts", nacc, 0);
    cal_success = 1'b1;
    cyc();
    chk("cal_accept", req_accept, 2'b01);
    chk("cal_grant", grant, 2'b01);
    chk("cal_amm_write", amm_write, 1);
    chk("cal_amm_read", amm_read, 0);
    chk("cal_busy", busy, 1);

    // Write burst of 4 with amm_ready stalls; calibration lost mid-burst
    req_valid = '0;
    cal_success = 1'b0;
    acks = 0;
    dones = 0;
    beat = 0;
    for (int i = 0; i < 6; i++) begin
      amm_ready = pat[i];
      req_wdata[255:0] = 256'hA0 + 256'(beat);
      req_be[31:0] = 32'hF0F0_0000 | 32'(beat);
      #1;
      chk("wr_ack", wbeat_ack, pat[i] ? 2'b01 : 2'b00);
      chk("wr_addr", amm_addr, 25'h10);
      chk("wr_burstcount", amm_burstcount, 4);
      chk("wr_data", amm_writedata, 256'hA0 + 256'(beat));
      chk("wr_be", amm_byteenable, 32'hF0F0_0000 | 32'(beat));
      if (wbeat_ack[0]) begin
        acks++;
        beat++;
      end
      if (req_done != '0) begin
        dones++;
        chk("wr_done_on_last", acks, 4);
        chk("wr_done_vec", req_done, 2'b01);
      end
      cyc();
    end
    amm_ready = 1'b0;
    chk("wr_ack_total", acks, 4);
    chk("wr_done_total", dones, 1);
    chk("wr_end_grant", grant, 0);
    chk("wr_end_busy", busy, 0);
    chk("wr_end_write", amm_write, 0);

    // Still uncalibrated: a new request must wait
    req_valid = 2'b10;
    req_write = 2'b00;
    req_addr[49:25] = 25'h77;
    req_burst[13:7] = 7'd1;
    nacc = 0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      if (req_accept != '0) nacc++;
    end
    chk("nocal2_accepts", nacc, 0);
    cal_success = 1'b1;
    cyc();
    chk("recal_accept", req_accept, 2'b10);
    chk("recal_addr", amm_addr, 25'h77);
    req_valid = '0;

    // Two continuous readers, burst 2 each: grants alternate with one idle cycle
    do_reset();
    cal_success = 1'b1;
    req_valid = 2'b11;
    req_write = 2'b00;
    req_addr = {25'h200, 25'h100};
    req_burst = {7'd2, 7'd2};
    amm_ready = 1'b1;
    nacc = 0;
    ndone = 0;
    pend = 0;
    seq = 0;
    prev_data = '0;
    rdv_cnt[0] = 0;
    rdv_cnt[1] = 0;
    guard = 0;
    while (ndone < 4 && guard < 80) begin
      guard++;
      if (amm_read && amm_write) chk("rd_rw_exclusive", 1, 0);
      if (req_accept != '0) begin
        if (nacc < 4) begin
          acc_seq[nacc] = req_accept;
          acc_cyc[nacc] = guard;
        end
        chk("rr_cmd_addr", amm_addr, req_accept[0] ? 25'h100 : 25'h200);
        nacc++;
      end
      if (rd_valid != '0) begin
        chk("rr_rd_data", rd_data, prev_data);
        if (rd_valid[0]) rdv_cnt[0]++;
        if (rd_valid[1]) rdv_cnt[1]++;
      end
      if (req_done != '0) begin
        done_cyc[ndone] = guard;
        chk("rr_done_idle", busy, 0);
        ndone++;
      end
      if (ndone == 4) req_valid = '0;
      if (pend > 0) begin
        amm_readdatavalid = 1'b1;
        amm_readdata = {8{32'hD000_0000 | 32'(seq)}};
        prev_data = amm_readdata;
        seq++;
        pend--;
      end else begin
        amm_readdatavalid = 1'b0;
      end
      if (amm_read) pend = 2;
      cyc();
    end
    amm_readdatavalid = 1'b0;
    chk("rr_done_count", ndone, 4);
    chk("rr_grant0", acc_seq[0], 2'b01);
    chk("rr_grant1", acc_seq[1], 2'b10);
    chk("rr_grant2", acc_seq[2], 2'b01);
    chk("rr_grant3", acc_seq[3], 2'b10);
    chk("rr_rdv_req0", rdv_cnt[0], 4);
    chk("rr_rdv_req1", rdv_cnt[1], 4);
    chk("rr_gap1", acc_cyc[1] - done_cyc[0], 1);
    chk("rr_gap2", acc_cyc[2] - done_cyc[1], 1);
    chk("rr_gap3", acc_cyc[3] - done_cyc[2], 1);

    // Stray readdatavalid while idle is dropped; burst 0 -> 1, burst 100 -> 64
    do_reset();
    cal_success = 1'b1;
    amm_ready = 1'b1;
    amm_readdatavalid = 1'b1;
    amm_readdata = {8{32'hBAD0_BAD0}};
    cyc();
    amm_readdatavalid = 1'b0;
    cyc();
    chk("stray_rdv", rd_valid, 0);
    chk("stray_data", rd_data, 0);
    req_valid = 2'b01;
    req_write = 2'b00;
    req_addr[24:0] = 25'h33;
    req_burst[6:0] = 7'd0;
    cyc();
    req_valid = '0;
    chk("b0_accept", req_accept, 2'b01);
    chk("b0_burstcount", amm_burstcount, 1);
    chk("b0_read", amm_read, 1);
    run_read(1, nrv, ndone);
    chk("b0_rdv", nrv, 1);
    chk("b0_done", ndone, 1);
    req_valid = 2'b01;
    req_burst[6:0] = 7'd100;
    cyc();
    req_valid = '0;
    chk("b100_burstcount", amm_burstcount, 64);
    run_read(64, nrv, ndone);
    chk("b100_rdv", nrv, 64);
    chk("b100_done", ndone, 1);

    // Asynchronous reset in the middle of an 8-beat write
    do_reset();
    cal_success = 1'b1;
    amm_ready = 1'b1;
    req_valid = 2'b10;
    req_write = 2'b11;
    req_addr[49:25] = 25'h40;
    req_burst[13:7] = 7'd8;
    cyc();
    req_valid = '0;
    chk("mid_accept", req_accept, 2'b10);
    chk("mid_ack0", wbeat_ack, 2'b10);
    cyc();
    chk("mid_ack1", wbeat_ack, 2'b10);
    cyc();
    avalon_reset = 1'b1;
    #1;
    chk("mid_rst_write", amm_write, 0);
    chk("mid_rst_grant", grant, 0);
    chk("mid_rst_busy", busy, 0);
    #1;
    avalon_reset = 1'b0;
    req_valid = 2'b11;
    req_write = 2'b00;
    cyc();
    chk("post_rst_accept", req_accept, 2'b01);
    req_valid = '0;

`ifdef ARB_RD_TIMEOUT_EN
    // Read that never returns data: watchdog fires after 16 RD_WAIT cycles
    do_reset();
    cal_success = 1'b1;
    amm_ready = 1'b1;
    req_valid = 2'b01;
    req_write = 2'b00;
    req_burst[6:0] = 7'd2;
    cyc();
    req_valid = '0;
    chk("tmo_read", amm_read, 1);
    cyc();
    chk("tmo_in_wait", amm_read, 0);
    for (int c = 0; c < 15; c++) cyc();
    chk("tmo_early_done", req_done, 0);
    chk("tmo_early_err", timeout_err, 0);
    cyc();
    chk("tmo_done", req_done, 2'b01);
    chk("tmo_err", timeout_err, 1);
    chk("tmo_idle", busy, 0);
    cyc();
    chk("tmo_err_sticky", timeout_err, 1);
    chk("tmo_done_pulse", req_done, 0);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
